// File: rtl/jedro_1_top_if.sv
// jedro_1_top_if: bus interfaces for the instruction ROM and the data RAM
// ram_read_io: addr/en from the master, data returned the cycle after the request
// ram_rw_io:   addr/wdata/we(byte enables)/en from the master, rdata returned the cycle after
interface ram_read_io #(parameter int DATA_WIDTH = 32, parameter int ADDR_WIDTH = 32);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  en;
  logic [DATA_WIDTH-1:0] data;
  modport MASTER (output addr, en, input data);
  modport SLAVE (input addr, en, output data);
endinterface

interface ram_rw_io;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  we;
  logic        en;
  modport MASTER (output addr, wdata, we, en, input rdata);
  modport SLAVE (input addr, wdata, we, en, output rdata);
endinterface

// File: rtl/jedro_1_top.sv
// jedro_1_top: multicycle RV32I core, FETCH -> EXEC -> (MEM) -> FETCH
// clk_i, rstn_i (async active-low); instr_mem_if: ROM fetch master; data_mem_if: load/store master
module jedro_1_regfile (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] regfile [32];
  assign rdata1 = raddr1 == 5'd0 ? 32'd0 : regfile[raddr1];
  assign rdata2 = raddr2 == 5'd0 ? 32'd0 : regfile[raddr2];
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) for (int i = 0; i < 32; i++) regfile[i] <= '0;
    else if (we && waddr != 5'd0) regfile[waddr] <= wdata;
endmodule

module jedro_1_top #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input logic        clk_i,
  input logic        rstn_i,
  ram_read_io.MASTER instr_mem_if,
  ram_rw_io.MASTER   data_mem_if
);
  localparam logic [1:0] FETCH = 2'd0, EXEC = 2'd1, MEM = 2'd2;
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67,
                         OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13, OP_REG = 7'h33;
  logic [1:0]  state;
  logic [31:0] pc, ir, rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] alu_b, alu, pc4, next_pc, ea, mem_addr, ex_wd, lane, ld_val, rf_wdata;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2, shamt, ld_rd, rf_waddr;
  logic [2:0]  f3, ld_f3;
  logic [1:0]  ld_off;
  logic [3:0]  be;
  logic        is_ld, is_st, is_mem, exec, taken, ex_we, ld_en, rf_we;
  assign ir     = instr_mem_if.data;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign imm_i  = {{20{ir[31]}}, ir[31:20]};
  assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u  = {ir[31:12], 12'd0};
  assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign is_ld  = opcode == OP_LD;
  assign is_st  = opcode == OP_ST;
  assign is_mem = is_ld || is_st;
  assign exec   = rstn_i && state == EXEC;
  assign pc4    = pc + 32'd4;
  assign alu_b  = opcode == OP_REG ? rs2_v : imm_i;
  assign shamt  = alu_b[4:0];
  always_comb begin
    alu = rs1_v + alu_b;
    case (f3)
      3'b000: alu = (opcode == OP_REG && ir[30]) ? rs1_v - alu_b : rs1_v + alu_b;
      3'b001: alu = rs1_v << shamt;
      3'b010: alu = {31'd0, $signed(rs1_v) < $signed(alu_b)};
      3'b011: alu = {31'd0, rs1_v < alu_b};
      3'b100: alu = rs1_v ^ alu_b;
      3'b101: alu = ir[30] ? 32'($signed(rs1_v) >>> shamt) : rs1_v >> shamt;
      3'b110: alu = rs1_v | alu_b;
      3'b111: alu = rs1_v & alu_b;
    endcase
  end
  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000: taken = rs1_v == rs2_v;
      3'b001: taken = rs1_v != rs2_v;
      3'b100: taken = $signed(rs1_v) < $signed(rs2_v);
      3'b101: taken = $signed(rs1_v) >= $signed(rs2_v);
      3'b110: taken = rs1_v < rs2_v;
      3'b111: taken = rs1_v >= rs2_v;
      default: taken = 1'b0;
    endcase
  end
  assign next_pc = opcode == OP_JAL ? pc + imm_j :
                   opcode == OP_JALR ? (rs1_v + imm_i) & ~32'd1 :
                   (opcode == OP_BR && taken) ? pc + imm_b : pc4;
  assign ex_we = opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL ||
                 opcode == OP_JALR || opcode == OP_IMM || opcode == OP_REG;
  assign ex_wd = opcode == OP_LUI ? imm_u :
                 opcode == OP_AUIPC ? pc + imm_u :
                 (opcode == OP_JAL || opcode == OP_JALR) ? pc4 : alu;
  // f3[1] selects word, f3[0] half, else byte; low address bits are masked to the access size
  assign ea       = rs1_v + (is_st ? imm_s : imm_i);
  assign mem_addr = f3[1] ? {ea[31:2], 2'b00} : f3[0] ? {ea[31:1], 1'b0} : ea;
  assign be       = f3[1] ? 4'hf : f3[0] ? (mem_addr[1] ? 4'hc : 4'h3) : 4'b0001 << mem_addr[1:0];
  assign instr_mem_if.addr = pc;
  assign instr_mem_if.en   = rstn_i && state == FETCH;
  assign data_mem_if.addr  = mem_addr;
  assign data_mem_if.wdata = f3[1] ? rs2_v : f3[0] ? {2{rs2_v[15:0]}} : {4{rs2_v[7:0]}};
  assign data_mem_if.en    = exec && is_mem;
  assign data_mem_if.we    = (exec && is_st) ? be : 4'h0;
  // ld_f3[2] marks the unsigned variants, which suppress sign extension
  assign lane   = data_mem_if.rdata >> {ld_off, 3'b000};
  assign ld_val = ld_f3[1] ? lane :
                  ld_f3[0] ? {{16{~ld_f3[2] & lane[15]}}, lane[15:0]} :
                             {{24{~ld_f3[2] & lane[7]}}, lane[7:0]};
  assign rf_we    = (exec && ex_we) || (state == MEM && ld_en);
  assign rf_waddr = state == MEM ? ld_rd : rd;
  assign rf_wdata = state == MEM ? ld_val : ex_wd;
  jedro_1_regfile regfile_inst (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_v),
    .rdata2 (rs2_v)
  );
  // the ROM output is not guaranteed past EXEC, so a load keeps what MEM needs
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state  <= FETCH;
      pc     <= BOOT_ADDR;
      ld_en  <= 1'b0;
      ld_rd  <= '0;
      ld_f3  <= '0;
      ld_off <= '0;
    end else begin
      state <= state == FETCH ? EXEC : (state == EXEC && is_mem) ? MEM : FETCH;
      if (state == EXEC) begin
        pc     <= next_pc;
        ld_en  <= is_ld;
        ld_rd  <= rd;
        ld_f3  <= f3;
        ld_off <= mem_addr[1:0];
      end
    end
endmodule

// File: tb/tb_jedro_1_top.sv
// tb_jedro_1_top: directed programs against ROM/RAM models with hand-computed register results
module tb_jedro_1_top;
  logic clk, rstn, clr;
  logic [31:0] rom [64];
  logic [31:0] dm [256];
  logic [31:0] fetch_log [$];
  logic [3:0]  last_we;
  logic [31:0] last_addr;
  int n_vec, n_err, ld;
  ram_read_io imem ();
  ram_rw_io   dmem ();
  jedro_1_top #(.BOOT_ADDR(32'h0)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .instr_mem_if (imem),
    .data_mem_if  (dmem)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < 256; k++) dm[k] <= '0;
      fetch_log.delete();
      last_we   <= '0;
      last_addr <= '0;
    end else begin
      if (imem.en) begin
        imem.data <= rom[imem.addr[7:2]];
        fetch_log.push_back(imem.addr);
      end
      if (dmem.en) begin
        dmem.rdata <= dm[dmem.addr[9:2]];
        for (int k = 0; k < 4; k++)
          if (dmem.we[k]) dm[dmem.addr[9:2]][8*k +: 8] <= dmem.wdata[8*k +: 8];
        if (|dmem.we) begin
          last_we   <= dmem.we;
          last_addr <= dmem.addr;
        end
      end
    end
  end
  function automatic logic [31:0] ei(input logic [31:0] imm, rs1, f3, rd, op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] er(input logic [31:0] f7, rs2, rs1, f3, rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] es(input logic [31:0] imm, rs2, rs1, f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] eb(input logic [31:0] imm, rs1, rs2, f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] eu(input logic [31:0] imm, rd, op);
    return {imm[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] ej(input logic [31:0] imm, rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction
  function automatic logic [31:0] addi(input logic [31:0] rd, rs1, imm);
    return ei(imm, rs1, 0, rd, 'h13);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_log(input string tag, input int idx, input logic [31:0] exp);
    chk(tag, idx < fetch_log.size() ? fetch_log[idx] : 32'hxxxx_xxxx, exp);
  endtask
  task automatic put(input logic [31:0] w);
    rom[ld] = w;
    ld++;
  endtask
  task automatic hold();
    @(negedge clk);
    rstn = 1'b0;
    clr  = 1'b1;
    ld   = 0;
    for (int k = 0; k < 64; k++) rom[k] = 32'h0000_0013;
  endtask
  task automatic release_rst();
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr  = 1'b0;
    rstn = 1'b1;
  endtask
  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic mem_prog();
    put(eu('hDEADC, 1, 'h37));
    put(addi(1, 1, -273));
    put(addi(2, 0, 'h100));
    put(es(0, 1, 2, 2));
    put(ei(0, 2, 0, 3, 3));
    put(ei(1, 2, 4, 4, 3));
    put(ei(2, 2, 1, 5, 3));
    put(addi(6, 0, 'h7A));
    put(es(2, 6, 2, 0));
    put(ei(0, 2, 2, 7, 3));
    put(ei(2, 2, 5, 8, 3));
    put(ej(0, 0));
  endtask
  initial begin
    n_vec = 0;
    n_err = 0;
    rstn  = 1'b0;
    clr   = 1'b1;
    hold();
    #1;
    chk("rst_imem_en", {31'd0, imem.en}, 0);
    chk("rst_dmem_en", {31'd0, dmem.en}, 0);
    chk("rst_dmem_we", {28'd0, dmem.we}, 0);
    chk("rst_pc", imem.addr, 0);
    put(addi(1, 0, -1));
    put(addi(3, 0, 5));
    put(eb(8, 3, 1, 5));
    put(addi(2, 2, 100));
    put(addi(2, 2, 1));
    put(eb(8, 1, 1, 5));
    put(addi(2, 2, 100));
    put(addi(2, 2, 2));
    put(eb(8, 1, 3, 5));
    put(addi(2, 2, 4));
    put(ej(0, 0));
    release_rst();
    chk_log("first_fetch", 0, 0);
    run(64);
    chk("bge_x1", dut.regfile_inst.regfile[1], 32'hFFFF_FFFF);
    chk("bge_x2", dut.regfile_inst.regfile[2], 7);
    hold();
    put(addi(1, 0, -1));
    put(addi(2, 0, 1));
    put(eb(8, 1, 2, 7));
    put(addi(10, 0, 'h55));
    put(addi(11, 0, 1));
    put(eb(8, 1, 2, 6));
    put(addi(12, 0, 1));
    put(ej(0, 0));
    release_rst();
    run(40);
    chk("bgeu_skip", dut.regfile_inst.regfile[10], 0);
    chk("bgeu_taken", dut.regfile_inst.regfile[11], 1);
    chk("bltu_not_taken", dut.regfile_inst.regfile[12], 1);
    hold();
    put(addi(3, 0, -5));
    put(ei('h401, 3, 5, 4, 'h13));
    put(ei(28, 3, 5, 5, 'h13));
    put(er(0, 3, 0, 3, 6));
    put(er('h20, 3, 0, 0, 7));
    put(eu('h12345, 8, 'h37));
    put(eu(1, 9, 'h17));
    put(er(0, 0, 3, 2, 13));
    put(ei(-1, 3, 4, 14, 'h13));
    put(ej(0, 0));
    release_rst();
    run(40);
    chk("addi_neg", dut.regfile_inst.regfile[3], 32'hFFFF_FFFB);
    chk("srai", dut.regfile_inst.regfile[4], 32'hFFFF_FFFD);
    chk("srli", dut.regfile_inst.regfile[5], 32'h0000_000F);
    chk("sltu", dut.regfile_inst.regfile[6], 1);
    chk("sub", dut.regfile_inst.regfile[7], 5);
    chk("lui", dut.regfile_inst.regfile[8], 32'h1234_5000);
    chk("auipc", dut.regfile_inst.regfile[9], 32'h0000_1018);
    chk("slt", dut.regfile_inst.regfile[13], 1);
    chk("xori", dut.regfile_inst.regfile[14], 4);
    hold();
    mem_prog();
    release_rst();
    run(60);
    chk("lui_addi", dut.regfile_inst.regfile[1], 32'hDEAD_BEEF);
    chk("lb", dut.regfile_inst.regfile[3], 32'hFFFF_FFEF);
    chk("lbu", dut.regfile_inst.regfile[4], 32'h0000_00BE);
    chk("lh", dut.regfile_inst.regfile[5], 32'hFFFF_DEAD);
    chk("sb_we", {28'd0, last_we}, 4'b0100);
    chk("sb_addr", last_addr, 32'h102);
    chk("sb_mem", dm[64], 32'hDE7A_BEEF);
    chk("lw", dut.regfile_inst.regfile[7], 32'hDE7A_BEEF);
    chk("lhu", dut.regfile_inst.regfile[8], 32'h0000_DE7A);
    hold();
    put(addi(5, 0, 1));
    ld = 4;
    put(ej(8, 1));
    put(addi(6, 0, 7));
    put(ei(1, 1, 0, 0, 'h67));
    release_rst();
    run(30);
    chk_log("fetch_jal", 4, 32'h10);
    chk_log("jal_target", 5, 32'h18);
    chk_log("jalr_target", 6, 32'h14);
    chk("jal_link", dut.regfile_inst.regfile[1], 32'h14);
    chk("after_jalr", dut.regfile_inst.regfile[6], 7);
    hold();
    mem_prog();
    release_rst();
    for (int c = 0; c < 40 && !(dmem.en === 1'b1 && dmem.we !== 4'h0); c++) @(negedge clk);
    chk("sw_request_we", {28'd0, dmem.we}, 4'hF);
    chk("pre_abort_x1", dut.regfile_inst.regfile[1], 32'hDEAD_BEEF);
    #2 rstn = 1'b0;
    #1;
    chk("abort_imem_en", {31'd0, imem.en}, 0);
    chk("abort_dmem_en", {31'd0, dmem.en}, 0);
    chk("abort_dmem_we", {28'd0, dmem.we}, 0);
    chk("abort_x1_clear", dut.regfile_inst.regfile[1], 0);
    chk("abort_x2_clear", dut.regfile_inst.regfile[2], 0);
    run(2);
    chk("abort_no_store", dm[64], 0);
    clr = 1'b1;
    ld  = 0;
    for (int k = 0; k < 64; k++) rom[k] = 32'h0000_0013;
    put(addi(0, 0, 5));
    put(addi(1, 0, 3));
    put(ej(0, 0));
    release_rst();
    run(12);
    chk_log("restart_pc", 0, 0);
    chk("x0_stays_zero", dut.regfile_inst.regfile[0], 0);
    chk("post_reset_x1", dut.regfile_inst.regfile[1], 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
